// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment select, pattern and code constants
// Used by the display driver, the encoder and the scan capture monitor.
package seg7_pkg;

  localparam logic [3:0] SEL_UNI  = 4'b1110;
  localparam logic [3:0] SEL_DEC  = 4'b1101;
  localparam logic [3:0] SEL_ACT  = 4'b1011;
  localparam logic [3:0] SEL_EST  = 4'b0111;
  localparam logic [3:0] SEL_IDLE = 4'b1111;

  localparam logic [6:0] SEG_0     = 7'h01;
  localparam logic [6:0] SEG_1     = 7'h4F;
  localparam logic [6:0] SEG_2     = 7'h12;
  localparam logic [6:0] SEG_3     = 7'h06;
  localparam logic [6:0] SEG_4     = 7'h4C;
  localparam logic [6:0] SEG_5     = 7'h24;
  localparam logic [6:0] SEG_6     = 7'h20;
  localparam logic [6:0] SEG_7     = 7'h0F;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h04;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_V     = 7'h41;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [4:0] CODE_A       = 5'h0A;
  localparam logic [4:0] CODE_V       = 5'h0B;
  localparam logic [4:0] CODE_BLANK   = 5'h1E;
  localparam logic [4:0] CODE_UNKNOWN = 5'h1F;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_PUBLISH = 1'b1
  } cap_state_t;

  function automatic logic sel_valid(input logic [3:0] sel);
    return (sel == SEL_UNI) || (sel == SEL_DEC) || (sel == SEL_ACT) || (sel == SEL_EST);
  endfunction

  function automatic logic [1:0] sel_pos(input logic [3:0] sel);
    case (sel)
      SEL_DEC: return 2'd1;
      SEL_ACT: return 2'd2;
      SEL_EST: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - active-low seven-segment pattern to symbol code
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [4:0] code
);

  always_comb begin
    code = CODE_UNKNOWN;
    case (pattern)
      SEG_0:     code = 5'd0;
      SEG_1:     code = 5'd1;
      SEG_2:     code = 5'd2;
      SEG_3:     code = 5'd3;
      SEG_4:     code = 5'd4;
      SEG_5:     code = 5'd5;
      SEG_6:     code = 5'd6;
      SEG_7:     code = 5'd7;
      SEG_8:     code = 5'd8;
      SEG_9:     code = 5'd9;
      SEG_A:     code = CODE_A;
      SEG_V:     code = CODE_V;
      SEG_BLANK: code = CODE_BLANK;
      default:   code = CODE_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// rtl/seg7_scan_capture.sv - multiplexed 4-digit display bus capture and frame publisher
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk_disp,
  input  logic       rst,
  input  logic [6:0] catodo_in,
  input  logic [3:0] seleccion_in,
  output logic [6:0] dig_raw0,
  output logic [6:0] dig_raw1,
  output logic [6:0] dig_raw2,
  output logic [6:0] dig_raw3,
  output logic [4:0] dig_code0,
  output logic [4:0] dig_code1,
  output logic [4:0] dig_code2,
  output logic [4:0] dig_code3,
  output logic       frame_valid,
  output logic       scan_error,
  output logic       link_lost
);

  localparam logic [3:0] STABLE_TGT  = 4'(STABLE_CYCLES);
  localparam logic [7:0] TIMEOUT_TGT = 8'(TIMEOUT_CYCLES);

  logic [3:0] s_sel, p_sel;
  logic [6:0] s_cat, p_cat;
  logic [3:0] stab_cnt, run_len;
  logic       same, at_target, accept, illegal;
  logic [7:0] idle_cnt;
  logic [3:0] seen, seen_set, seen_nxt;
  logic [6:0] shadow [4];
  logic [6:0] raw_q  [4];
  logic       publish;
  cap_state_t state, state_nxt;

  always_ff @(posedge clk_disp or posedge rst) begin
    if (rst) begin
      s_sel    <= SEL_IDLE;
      s_cat    <= SEG_BLANK;
      p_sel    <= SEL_IDLE;
      p_cat    <= SEG_BLANK;
      stab_cnt <= '0;
    end else begin
      s_sel    <= seleccion_in;
      s_cat    <= catodo_in;
      p_sel    <= s_sel;
      p_cat    <= s_cat;
      stab_cnt <= run_len;
    end
  end

  // A saturated run sitting at the target must not fire a second time.
  always_comb begin
    same    = ({s_sel, s_cat} == {p_sel, p_cat});
    run_len = 4'd1;
    if (same) run_len = (stab_cnt == 4'hF) ? 4'hF : stab_cnt + 4'd1;
    at_target = (run_len == STABLE_TGT) && !(same && (stab_cnt == STABLE_TGT));
    accept    = at_target && sel_valid(s_sel);
    illegal   = at_target && !sel_valid(s_sel) && (s_sel != SEL_IDLE);
  end

  always_comb begin
    seen_set  = accept ? (4'b0001 << sel_pos(s_sel)) : 4'b0000;
    seen_nxt  = seen | seen_set;
    state_nxt = state;
    publish   = 1'b0;
    case (state)
      ST_COLLECT: if ((seen | seen_set) == 4'hF) state_nxt = ST_PUBLISH;
      ST_PUBLISH: begin
        publish   = 1'b1;
        seen_nxt  = seen_set;
        state_nxt = ST_COLLECT;
      end
      default: state_nxt = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk_disp or posedge rst) begin
    if (rst) begin
      state       <= ST_COLLECT;
      seen        <= '0;
      frame_valid <= 1'b0;
      scan_error  <= 1'b0;
      idle_cnt    <= '0;
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= SEG_BLANK;
        raw_q[i]  <= SEG_BLANK;
      end
    end else begin
      state       <= state_nxt;
      seen        <= seen_nxt;
      frame_valid <= publish;
      if (illegal) scan_error <= 1'b1;
      if (accept) shadow[sel_pos(s_sel)] <= s_cat;
      if (publish) begin
        for (int i = 0; i < 4; i++) raw_q[i] <= shadow[i];
      end
      if (accept) idle_cnt <= '0;
      else if (idle_cnt != 8'hFF) idle_cnt <= idle_cnt + 8'd1;
    end
  end

  assign link_lost = (idle_cnt >= TIMEOUT_TGT);
  assign dig_raw0  = raw_q[0];
  assign dig_raw1  = raw_q[1];
  assign dig_raw2  = raw_q[2];
  assign dig_raw3  = raw_q[3];

  seg7_decode u_dec0 (.pattern(raw_q[0]), .code(dig_code0));
  seg7_decode u_dec1 (.pattern(raw_q[1]), .code(dig_code1));
  seg7_decode u_dec2 (.pattern(raw_q[2]), .code(dig_code2));
  seg7_decode u_dec3 (.pattern(raw_q[3]), .code(dig_code3));

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb/tb_seg7_scan_capture.sv - bench for seg7_scan_capture with STABLE_CYCLES 1 and 3
module tb_seg7_scan_capture;

  logic       clk_disp = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] catodo_in = 7'h7F;
  logic [3:0] seleccion_in = 4'hF;

  logic [1:0][3:0][6:0] raw;
  logic [1:0][3:0][4:0] code;
  logic [1:0]           fv, err, ll;

  always #5 clk_disp = ~clk_disp;

  seg7_scan_capture #(.STABLE_CYCLES(1), .TIMEOUT_CYCLES(64)) dut_s1 (
    .clk_disp(clk_disp), .rst(rst), .catodo_in(catodo_in), .seleccion_in(seleccion_in),
    .dig_raw0(raw[0][0]), .dig_raw1(raw[0][1]), .dig_raw2(raw[0][2]), .dig_raw3(raw[0][3]),
    .dig_code0(code[0][0]), .dig_code1(code[0][1]), .dig_code2(code[0][2]), .dig_code3(code[0][3]),
    .frame_valid(fv[0]), .scan_error(err[0]), .link_lost(ll[0]));

  seg7_scan_capture #(.STABLE_CYCLES(3), .TIMEOUT_CYCLES(10)) dut_s3 (
    .clk_disp(clk_disp), .rst(rst), .catodo_in(catodo_in), .seleccion_in(seleccion_in),
    .dig_raw0(raw[1][0]), .dig_raw1(raw[1][1]), .dig_raw2(raw[1][2]), .dig_raw3(raw[1][3]),
    .dig_code0(code[1][0]), .dig_code1(code[1][1]), .dig_code2(code[1][2]), .dig_code3(code[1][3]),
    .frame_valid(fv[1]), .scan_error(err[1]), .link_lost(ll[1]));

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int fv_seen [2];
  int stab_of [2] = '{1, 3};
  int tmo_of  [2] = '{64, 10};
  logic [6:0] digit_seg [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};
  logic [3:0] sel_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  // Reference model: acceptance events on the applied input stream, frames as sets of positions.
  logic [3:0] m_psel [2];
  logic [6:0] m_pcat [2];
  int         m_run  [2];
  bit         m_done [2];
  bit   [3:0] m_seen [2];
  logic [6:0] m_shadow [2][4];
  bit         r_clr [2][8];
  bit         r_err [2][8];
  bit         r_pub [2][8];
  logic [6:0] r_raw [2][8][4];
  logic [6:0] e_raw [2][4];
  bit         e_err [2];
  int         e_lastclr [2];

  typedef struct {
    logic [6:0] pat;
    logic [4:0] code;
  } vec_t;
  vec_t tbl [14];

  always @(posedge clk_disp) edge_n <= edge_n + 1;

  function automatic logic [4:0] ref_code(input logic [6:0] p);
    for (int d = 0; d < 10; d++) if (digit_seg[d] == p) return 5'(d);
    if (p == 7'h08) return 5'h0A;
    if (p == 7'h41) return 5'h0B;
    if (p == 7'h7F) return 5'h1E;
    return 5'h1F;
  endfunction

  task automatic chk(input string nm, input int k, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at edge %0d", nm, k, act, want, edge_n);
    end
  endtask

  task automatic model_reset(input int r);
    for (int k = 0; k < 2; k++) begin
      m_psel[k] = 4'hF; m_pcat[k] = 7'h7F; m_run[k] = 1; m_done[k] = 1'b0;
      m_seen[k] = '0; e_err[k] = 1'b0; e_lastclr[k] = r; fv_seen[k] = 0;
      for (int q = 0; q < 4; q++) begin m_shadow[k][q] = 7'h7F; e_raw[k][q] = 7'h7F; end
      for (int s = 0; s < 8; s++) begin r_clr[k][s] = 0; r_err[k][s] = 0; r_pub[k][s] = 0; end
    end
  endtask

  task automatic model_apply(input logic [3:0] sel, input logic [6:0] cat, input int n);
    int pos;
    for (int k = 0; k < 2; k++) begin
      if (sel == m_psel[k] && cat == m_pcat[k]) m_run[k] = (m_run[k] < 15) ? m_run[k] + 1 : 15;
      else begin m_run[k] = 1; m_done[k] = 1'b0; end
      m_psel[k] = sel; m_pcat[k] = cat;
      if (m_run[k] == stab_of[k] && !m_done[k]) begin
        m_done[k] = 1'b1;
        if ($countones(~sel) == 1) begin
          pos = 0;
          for (int p = 0; p < 4; p++) if (!sel[p]) pos = p;
          r_clr[k][(n + 1) % 8] = 1;
          m_shadow[k][pos] = cat;
          m_seen[k][pos] = 1'b1;
          if (m_seen[k] == 4'hF) begin
            r_pub[k][(n + 2) % 8] = 1;
            for (int q = 0; q < 4; q++) r_raw[k][(n + 2) % 8][q] = m_shadow[k][q];
            m_seen[k] = '0;
          end
        end else if (sel != 4'hF) begin
          r_err[k][(n + 1) % 8] = 1;
        end
      end
    end
  endtask

  task automatic check_all(input int m);
    int s;
    bit want_fv;
    s = m % 8;
    for (int k = 0; k < 2; k++) begin
      if (r_clr[k][s]) e_lastclr[k] = m;
      if (r_err[k][s]) e_err[k] = 1'b1;
      want_fv = r_pub[k][s];
      if (r_pub[k][s]) for (int q = 0; q < 4; q++) e_raw[k][q] = r_raw[k][s][q];
      r_clr[k][s] = 0; r_err[k][s] = 0; r_pub[k][s] = 0;
      if (fv[k]) fv_seen[k]++;
      chk("frame_valid", k, int'(fv[k]), int'(want_fv));
      chk("scan_error", k, int'(err[k]), int'(e_err[k]));
      chk("link_lost", k, int'(ll[k]), int'((m - e_lastclr[k]) >= tmo_of[k]));
      for (int q = 0; q < 4; q++) begin
        chk($sformatf("dig_raw%0d", q), k, int'(raw[k][q]), int'(e_raw[k][q]));
        chk($sformatf("dig_code%0d", q), k, int'(code[k][q]), int'(ref_code(e_raw[k][q])));
      end
    end
  endtask

  task automatic apply(input logic [3:0] sel, input logic [6:0] cat);
    seleccion_in = sel;
    catodo_in    = cat;
    model_apply(sel, cat, edge_n + 1);
  endtask

  task automatic step(input logic [3:0] sel, input logic [6:0] cat);
    @(negedge clk_disp);
    check_all(edge_n);
    apply(sel, cat);
  endtask

  task automatic hold(input logic [3:0] sel, input logic [6:0] cat, input int n);
    for (int i = 0; i < n; i++) step(sel, cat);
  endtask

  task automatic round(input int n);
    hold(4'hE, 7'h24, n); hold(4'hD, 7'h12, n); hold(4'hB, 7'h08, n); hold(4'h7, 7'h4F, n);
  endtask

  // Reset is raised between edges so the asynchronous clear is observed before any clock.
  task automatic pulse_reset();
    @(posedge clk_disp);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst frame_valid", k, int'(fv[k]), 0);
      chk("rst scan_error", k, int'(err[k]), 0);
      chk("rst link_lost", k, int'(ll[k]), 0);
      for (int q = 0; q < 4; q++) begin
        chk("rst dig_raw", k, int'(raw[k][q]), 'h7F);
        chk("rst dig_code", k, int'(code[k][q]), 'h1E);
      end
    end
    @(negedge clk_disp);
    @(negedge clk_disp);
    rst = 1'b0;
    model_reset(edge_n);
    apply(4'hF, 7'h7F);
  endtask

  initial begin
    logic [3:0] rs;
    logic [6:0] rc;
    tbl[0]  = '{7'h01, 5'h00}; tbl[1]  = '{7'h4F, 5'h01}; tbl[2]  = '{7'h12, 5'h02};
    tbl[3]  = '{7'h06, 5'h03}; tbl[4]  = '{7'h4C, 5'h04}; tbl[5]  = '{7'h24, 5'h05};
    tbl[6]  = '{7'h20, 5'h06}; tbl[7]  = '{7'h0F, 5'h07}; tbl[8]  = '{7'h00, 5'h08};
    tbl[9]  = '{7'h04, 5'h09}; tbl[10] = '{7'h08, 5'h0A}; tbl[11] = '{7'h41, 5'h0B};
    tbl[12] = '{7'h7F, 5'h1E}; tbl[13] = '{7'h55, 5'h1F};
    model_reset(0);

    pulse_reset();

    for (int i = 0; i < 10; i++) round(1);
    hold(4'hF, 7'h7F, 3);
    chk("frames fast scan", 0, fv_seen[0], 10);
    chk("frames fast scan", 1, fv_seen[1], 0);
    chk("code0", 0, int'(code[0][0]), 5); chk("code1", 0, int'(code[0][1]), 2);
    chk("code2", 0, int'(code[0][2]), 'h0A); chk("code3", 0, int'(code[0][3]), 1);
    chk("raw0", 0, int'(raw[0][0]), 'h24); chk("raw1", 0, int'(raw[0][1]), 'h12);
    chk("raw2", 0, int'(raw[0][2]), 'h08); chk("raw3", 0, int'(raw[0][3]), 'h4F);

    fv_seen[0] = 0; fv_seen[1] = 0;
    for (int i = 0; i < 3; i++) round(2);
    chk("frames hold2", 1, fv_seen[1], 0);
    for (int i = 0; i < 3; i++) round(3);
    hold(4'hF, 7'h7F, 4);
    chk("frames hold3", 1, fv_seen[1], 3);
    chk("frames hold2+3", 0, fv_seen[0], 6);

    step(4'hE, 7'h24); step(4'hD, 7'h12); step(4'hF, 7'h7F);
    chk("raw1 before reset", 0, int'(raw[0][1]), 'h12);
    pulse_reset();
    step(4'hE, 7'h24); step(4'hD, 7'h12); step(4'hB, 7'h08);
    hold(4'hF, 7'h7F, 4);
    chk("frames after reset partial", 0, fv_seen[0], 0);
    step(4'h7, 7'h4F);
    hold(4'hF, 7'h7F, 4);
    chk("frames after reset full", 0, fv_seen[0], 1);

    for (int t = 0; t < 14; t++) begin
      hold(4'hE, 7'h24, 3); hold(4'hD, tbl[t].pat, 3); hold(4'hB, 7'h08, 3); hold(4'h7, 7'h4F, 3);
      hold(4'hF, 7'h7F, 4);
      for (int k = 0; k < 2; k++) begin
        chk("table dig_raw1", k, int'(raw[k][1]), int'(tbl[t].pat));
        chk("table dig_code1", k, int'(code[k][1]), int'(tbl[t].code));
      end
    end

    chk("scan_error clean", 0, int'(err[0]), 0);
    step(4'hE, 7'h24); step(4'b1100, 7'h12);
    hold(4'hF, 7'h7F, 3);
    chk("scan_error set", 0, int'(err[0]), 1);
    round(1); round(1);
    hold(4'hF, 7'h7F, 4);
    chk("scan_error sticky", 0, int'(err[0]), 1);
    chk("code1 after error", 0, int'(code[0][1]), 2);
    hold(4'b1100, 7'h12, 3);
    hold(4'hF, 7'h7F, 2);
    chk("scan_error set", 1, int'(err[1]), 1);

    hold(4'hF, 7'h7F, 70);
    chk("link_lost idle", 0, int'(ll[0]), 1);
    round(1);
    hold(4'hF, 7'h7F, 2);
    chk("link_lost resumed", 0, int'(ll[0]), 0);

    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 9) < 2) ? 4'hF : sel_tab[$urandom_range(0, 3)];
      rc = ($urandom_range(0, 3) == 0) ? 7'($urandom) : digit_seg[$urandom_range(0, 9)];
      hold(rs, rc, $urandom_range(1, 4));
    end
    hold(4'hF, 7'h7F, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
